// File: rtl/prbs_pkg.sv
// Shared PRBS31 constants and lock-checker state type; used by the generator and the checker.
package prbs_pkg;

  localparam int PRBS_LEN = 31;
  localparam int TAP_HI   = 30;
  localparam int TAP_LO   = 27;

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } chk_state_t;

endpackage

// File: rtl/prbs31_lfsr_step.sv
// Combinational PRBS31 step (x^31+x^28+1): predicted bit and shifted next state.
module prbs31_lfsr_step
  import prbs_pkg::*;
(
  input  logic [PRBS_LEN-1:0] state_i,
  input  logic                bit_i,
  output logic                pred_o,
  output logic [PRBS_LEN-1:0] next_o
);

  assign pred_o = state_i[TAP_HI] ^ state_i[TAP_LO];
  assign next_o = {state_i[PRBS_LEN-2:0], bit_i};

endmodule

// File: rtl/prbs31_lock_checker.sv
// Self-synchronising PRBS31 checker: SEED -> VERIFY -> LOCKED, with saturating BER counters.
// Optional macro PRBS_CNT_CLEAR_EN adds a cnt_clear input that zeroes the three counters.
module prbs31_lock_checker
  import prbs_pkg::*;
#(
  parameter int LOCK_THRESHOLD = 64,
  parameter int LOSS_WINDOW    = 128,
  parameter int LOSS_THRESHOLD = 16,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 data_in,
  input  logic                 data_in_valid,
`ifdef PRBS_CNT_CLEAR_EN
  input  logic                 cnt_clear,
`endif
  output logic                 locked,
  output logic [CNT_WIDTH-1:0] total_bits,
  output logic [CNT_WIDTH-1:0] total_bit_errors,
  output logic [CNT_WIDTH-1:0] relock_count
);

  localparam int SEED_W = $clog2(PRBS_LEN + 1);
  localparam int GOOD_W = $clog2(LOCK_THRESHOLD + 1);
  localparam int WIN_W  = $clog2(LOSS_WINDOW + 1);
  localparam int WERR_W = $clog2(LOSS_THRESHOLD + 1);

  localparam logic [SEED_W-1:0] SEED_LAST = SEED_W'(PRBS_LEN - 1);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_THRESHOLD - 1);
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(LOSS_WINDOW - 1);
  localparam logic [WERR_W-1:0] WERR_LAST = WERR_W'(LOSS_THRESHOLD - 1);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  chk_state_t            state_q, state_d;
  logic [PRBS_LEN-1:0]   lfsr_q, lfsr_d, lfsr_next;
  logic [SEED_W-1:0]     seed_cnt_q, seed_cnt_d;
  logic [GOOD_W-1:0]     good_cnt_q, good_cnt_d;
  logic [WIN_W-1:0]      win_cnt_q, win_cnt_d;
  logic [WERR_W-1:0]     win_err_q, win_err_d;
  logic                  locked_q, locked_d;
  logic [CNT_WIDTH-1:0]  bits_q, bits_d, errs_q, errs_d, relock_q, relock_d;
  logic                  pred, shift_bit, miss;

  // Locked: the LFSR free-runs on its own prediction; otherwise it learns from the line.
  assign shift_bit = (state_q == LOCKED) ? pred : data_in;
  assign miss      = data_in ^ pred;

  prbs31_lfsr_step u_step (
    .state_i (lfsr_q),
    .bit_i   (shift_bit),
    .pred_o  (pred),
    .next_o  (lfsr_next)
  );

  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    seed_cnt_d = seed_cnt_q;
    good_cnt_d = good_cnt_q;
    win_cnt_d  = win_cnt_q;
    win_err_d  = win_err_q;
    locked_d   = locked_q;
    bits_d     = bits_q;
    errs_d     = errs_q;
    relock_d   = relock_q;
    if (data_in_valid) begin
      lfsr_d = lfsr_next;
      case (state_q)
        SEED: begin
          seed_cnt_d = seed_cnt_q + 1'b1;
          if (seed_cnt_q == SEED_LAST) begin
            state_d    = VERIFY;
            seed_cnt_d = '0;
            good_cnt_d = '0;
          end
        end
        VERIFY: begin
          if (miss) begin
            state_d    = SEED;
            seed_cnt_d = '0;
          end else begin
            good_cnt_d = good_cnt_q + 1'b1;
            if (good_cnt_q == GOOD_LAST) begin
              state_d   = LOCKED;
              locked_d  = 1'b1;
              win_cnt_d = '0;
              win_err_d = '0;
            end
          end
        end
        LOCKED: begin
          bits_d = sat_inc(bits_q);
          if (miss) errs_d = sat_inc(errs_q);
          // Loss beats window rollover when both land on the same bit.
          if (miss && (win_err_q == WERR_LAST)) begin
            state_d    = SEED;
            locked_d   = 1'b0;
            relock_d   = sat_inc(relock_q);
            seed_cnt_d = '0;
            win_cnt_d  = '0;
            win_err_d  = '0;
          end else if (win_cnt_q == WIN_LAST) begin
            win_cnt_d = '0;
            win_err_d = '0;
          end else begin
            win_cnt_d = win_cnt_q + 1'b1;
            win_err_d = win_err_q + WERR_W'(miss);
          end
        end
        default: state_d = SEED;
      endcase
    end
`ifdef PRBS_CNT_CLEAR_EN
    if (cnt_clear) begin
      bits_d   = '0;
      errs_d   = '0;
      relock_d = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= SEED;
      lfsr_q     <= '0;
      seed_cnt_q <= '0;
      good_cnt_q <= '0;
      win_cnt_q  <= '0;
      win_err_q  <= '0;
      locked_q   <= 1'b0;
      bits_q     <= '0;
      errs_q     <= '0;
      relock_q   <= '0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      seed_cnt_q <= seed_cnt_d;
      good_cnt_q <= good_cnt_d;
      win_cnt_q  <= win_cnt_d;
      win_err_q  <= win_err_d;
      locked_q   <= locked_d;
      bits_q     <= bits_d;
      errs_q     <= errs_d;
      relock_q   <= relock_d;
    end
  end

  assign locked           = locked_q;
  assign total_bits       = bits_q;
  assign total_bit_errors = errs_q;
  assign relock_count     = relock_q;

endmodule

// File: tb/tb_prbs31_lock_checker.sv
// Randomised bench for prbs31_lock_checker against a history-based behavioural model.
module tb_prbs31_lock_checker;

  logic        clk = 1'b0;
  logic        rstn, din, vin, clr_s;
  logic        locked;
  logic [31:0] total_bits, total_bit_errors, relock_count;
  logic        rstn2, din2, vin2;
  logic        locked2;
  logic [3:0]  bits2, errs2, relock2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  prbs31_lock_checker dut (
    .clk(clk), .rstn(rstn), .data_in(din), .data_in_valid(vin),
`ifdef PRBS_CNT_CLEAR_EN
    .cnt_clear(clr_s),
`endif
    .locked(locked), .total_bits(total_bits),
    .total_bit_errors(total_bit_errors), .relock_count(relock_count)
  );

  prbs31_lock_checker #(.LOSS_THRESHOLD(32), .CNT_WIDTH(4)) dut_sat (
    .clk(clk), .rstn(rstn2), .data_in(din2), .data_in_valid(vin2),
`ifdef PRBS_CNT_CLEAR_EN
    .cnt_clear(1'b0),
`endif
    .locked(locked2), .total_bits(bits2),
    .total_bit_errors(errs2), .relock_count(relock2)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference PRBS source: each new bit is the XOR of the bits 31 and 28 positions back.
  bit gen_q[$];
  function automatic bit gen_next();
    bit b;
    b = gen_q[0] ^ gen_q[3];
    gen_q.push_back(b);
    void'(gen_q.pop_front());
    return b;
  endfunction

  // Behavioural model: hist holds the last 31 reference bits, oldest first.
  localparam longint CMAX = 64'hFFFF_FFFF;
  bit     hist[$];
  int     m_mode;             // 0 seeding, 1 verifying, 2 locked
  int     m_seed, m_good, m_winc, m_wine;
  bit     m_locked;
  longint m_bits, m_errs, m_relock;

  function automatic longint sat(input longint v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic model_step(input bit d, input bit v, input bit rn, input bit clr);
    bit p;
    if (!rn) begin
      hist.delete();
      for (int i = 0; i < 31; i++) hist.push_back(1'b0);
      m_mode = 0; m_seed = 0; m_good = 0; m_winc = 0; m_wine = 0;
      m_locked = 0; m_bits = 0; m_errs = 0; m_relock = 0;
      return;
    end
    if (v) begin
      p = hist[0] ^ hist[3];
      hist.push_back(m_mode == 2 ? p : d);
      void'(hist.pop_front());
      if (m_mode == 0) begin
        m_seed++;
        if (m_seed == 31) begin m_mode = 1; m_good = 0; end
      end else if (m_mode == 1) begin
        if (d == p) begin
          m_good++;
          if (m_good == 64) begin m_mode = 2; m_locked = 1; m_winc = 0; m_wine = 0; end
        end else begin
          m_mode = 0; m_seed = 0;
        end
      end else begin
        m_bits = sat(m_bits);
        if (d != p) m_errs = sat(m_errs);
        m_winc++;
        if (d != p) m_wine++;
        if (m_wine >= 16) begin
          m_mode = 0; m_locked = 0; m_relock = sat(m_relock);
          m_seed = 0; m_winc = 0; m_wine = 0;
        end else if (m_winc == 128) begin
          m_winc = 0; m_wine = 0;
        end
      end
    end
`ifdef PRBS_CNT_CLEAR_EN
    if (clr) begin m_bits = 0; m_errs = 0; m_relock = 0; end
`endif
  endtask

  task automatic cycle(input bit d, input bit v, input bit rn, input bit clr);
    din = d; vin = v; rstn = rn; clr_s = clr;
    @(posedge clk);
    model_step(d, v, rn, clr);
    #1;
    chk("locked", locked, m_locked);
    chk("total_bits", total_bits, m_bits);
    chk("total_bit_errors", total_bit_errors, m_errs);
    chk("relock_count", relock_count, m_relock);
  endtask

  task automatic send_bits(input int n, input bit inv);
    for (int i = 0; i < n; i++) cycle(gen_next() ^ inv, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic sat_bit(input bit d);
    din2 = d; vin2 = 1'b1; rstn2 = 1'b1;
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    vin2 = 1'b0;
  endtask

  initial begin
    int pad, cyc;
    longint hold_b, hold_e;
    bit v, e;
    din = 0; vin = 0; rstn = 0; clr_s = 0;
    din2 = 0; vin2 = 0; rstn2 = 0;
    for (int i = 0; i < 31; i++) gen_q.push_back(1'($urandom_range(0, 1)));
    gen_q[0] = 1'b1;
    @(negedge clk);
    do_reset(); do_reset();
    chk("rst_locked", locked, 0);
    chk("rst_bits", total_bits, 0);

    // Clean lock: locked rises exactly with valid bit 95.
    send_bits(94, 1'b0);
    chk("lock_early", locked, 0);
    send_bits(1, 1'b0);
    chk("lock_at_95", locked, 1);
    send_bits(200, 1'b0);
    chk("clean_bits", total_bits, 200);
    chk("clean_errs", total_bit_errors, 0);

    // Single error.
    send_bits(1, 1'b1);
    send_bits(50, 1'b0);
    chk("single_errs", total_bit_errors, 1);
    chk("single_locked", locked, 1);
    chk("single_relock", relock_count, 0);

    // Burst loss aligned to a fresh window.
    pad = 0;
    while (m_winc != 0 && pad < 200) begin send_bits(1, 1'b0); pad++; end
    chk("window_align", pad < 200, 1);
    send_bits(15, 1'b1);
    chk("burst_15_locked", locked, 1);
    send_bits(1, 1'b1);
    chk("burst_16_locked", locked, 0);
    chk("burst_relock", relock_count, 1);
    chk("burst_errs", total_bit_errors, 17);
    hold_b = total_bits; hold_e = total_bit_errors;
    send_bits(94, 1'b0);
    chk("relock_early", locked, 0);
    chk("held_bits", total_bits, hold_b);
    chk("held_errs", total_bit_errors, hold_e);
    send_bits(1, 1'b0);
    chk("relock_at_95", locked, 1);

    // Valid gaps with garbage on invalid cycles.
    do_reset();
    cyc = 0;
    for (int i = 0; i < 95; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b0);
      send_bits(1, 1'b0);
      cyc += 2;
    end
    chk("gap_locked", locked, 1);
    chk("gap_cycles", cyc, 190);
    for (int i = 0; i < 100; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b0);
      send_bits(1, 1'b0);
    end
    chk("gap_bits", total_bits, 100);

    // Random traffic with alternating low and high error rates.
    for (int blk = 0; blk < 8; blk++) begin
      for (int i = 0; i < 500; i++) begin
        v = ($urandom_range(0, 3) != 0);
        e = ($urandom_range(0, (blk % 2) ? 6 : 80) == 0);
        if (v) cycle(gen_next() ^ e, 1'b1, 1'b1, 1'b0);
        else   cycle(1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b0);
      end
    end

    // Reset while locked.
    do_reset();
    send_bits(120, 1'b0);
    chk("pre_rst_locked", locked, 1);
    cycle(gen_next(), 1'b1, 1'b0, 1'b0);
    chk("midrst_locked", locked, 0);
    chk("midrst_bits", total_bits, 0);
    chk("midrst_errs", total_bit_errors, 0);
    chk("midrst_relock", relock_count, 0);

`ifdef PRBS_CNT_CLEAR_EN
    send_bits(130, 1'b0);
    send_bits(1, 1'b1);
    cycle(gen_next() ^ 1'b1, 1'b1, 1'b1, 1'b1);
    chk("clr_bits", total_bits, 0);
    chk("clr_errs", total_bit_errors, 0);
    chk("clr_locked", locked, 1);
    send_bits(5, 1'b0);
    chk("clr_after", total_bits, 5);
`endif

    // Saturation on the 4-bit instance.
    rstn2 = 1'b0;
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 95; i++) sat_bit(gen_next());
    chk("sat_locked0", locked2, 1);
    for (int i = 0; i < 10; i++) sat_bit(gen_next() ^ 1'b1);
    chk("sat_errs10", errs2, 10);
    for (int i = 0; i < 10; i++) sat_bit(gen_next() ^ 1'b1);
    chk("sat_errs", errs2, 15);
    chk("sat_bits", bits2, 15);
    chk("sat_locked", locked2, 1);
    chk("sat_relock", relock2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
